reg_file_sb: RTL
================

# reg_file_sb

Architectural register file with an integrated pending-write scoreboard; the write-back stage drives its write port, and the decode stage reads operands and receives a stall request from it. Holds R0–R14 as 32-bit registers, returns `pc_in` for R15, and bypasses a same-cycle write-back to the read ports. A per-register in-flight counter tracks issued-but-not-written destinations and raises `hazard` when decode sources a pending register.

## Interface
- `NREG`, default 15: number of storage registers (R0..R14); address 15 maps to `pc_in`.
- `CNT_W`, default 2: width of each pending counter; saturates at 2^CNT_W−1.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `src1_addr`  in  4  Rn read address
- `src1_valid`  in  1  Rn is used by the decoding instruction
- `src2_addr`  in  4  Rm read address
- `src2_valid`  in  1  Rm is used by the decoding instruction
- `pc_in`  in  32  value returned for address 15
- `rn_value`  out  32  read data port 1 (combinational)
- `rm_value`  out  32  read data port 2 (combinational)
- `wb_dest`  in  4  write-back destination
- `wb_value`  in  32  write-back data
- `wb_wb_en`  in  1  write-back enable
- `iss_valid`  in  1  instruction leaves decode this cycle
- `iss_dest`  in  4  its destination
- `iss_wb_en`  in  1  it will write back
- `flush`  in  1  clear all pending counters
- `hazard`  out  1  decode must stall (combinational)

## Operation
- Storage: `regs[0..14]`, 32 bits each; `cnt[0..14]`, CNT_W bits each.
- Reset (`rst`=0, async): all `regs` and all `cnt` clear to 0. Consequently `rn_value`/`rm_value`=0 for addresses 0–14, `pc_in` for address 15, and `hazard`=0.
- Write: on rising `clk`, if `wb_wb_en` and `wb_dest`≠15, then `regs[wb_dest]`←`wb_value`. Writes to 15 are dropped.
- Read, per port: address 15 → `pc_in`; else if `wb_wb_en` and `wb_dest`==addr → `wb_value` (bypass); else `regs[addr]`.
- Counters, per register r≠15, evaluated every cycle:
  - inc = `iss_valid` & `iss_wb_en` & `iss_dest`==r; dec = `wb_wb_en` & `wb_dest`==r.
  - `flush`: cnt←0, overriding inc/dec.
  - inc&dec: unchanged. inc only: +1, saturating at max. dec only: −1, floored at 0 (a stray write-back is ignored).
- Issue to dest 15 never touches any counter.
- The caller gates `iss_valid` with `!hazard`; the block does not self-gate.
- Pending(r) = cnt[r]≠0 and not (cnt[r]==1 and dec(r)). The last outstanding write landing this cycle is covered by the bypass.
- `hazard` = (`src1_valid` & addr1≠15 & pending(addr1)) | (`src2_valid` & addr2≠15 & pending(addr2)).
- `hazard` uses current counter values. An issue in the same cycle does not affect it.

## Timing
- Write latency: data is visible via bypass in the same cycle and via storage from the next edge.
- Counter update: visible one cycle after the issue or write-back edge.
- `hazard`, `rn_value` and `rm_value` are purely combinational from inputs and state, with no registered outputs.
- A `flush` asserted in the same cycle as a write-back: the register write still occurs and counters clear.
- Reset mid-operation clears state immediately, independent of `clk`.

## Test plan
- Reset then read R3 and R15 with `pc_in`=0x100 → `rn_value`=0, `rm_value`=0x100, `hazard`=0.
- WB R5=0xDEADBEEF while reading R5 in the same cycle → `rn_value`=0xDEADBEEF that cycle and after; WB to R15 then read R15 → returns `pc_in`.
- Issue to R2 (cnt→1), next cycle decode with src1=R2 → `hazard`=1. Then WB R2=7 → `hazard`=0 in the WB cycle and `rn_value`=7.
- Issue R4 three cycles in a row, then a fourth time → cnt saturates at 3; four WBs → cnt reaches 0 after the third, and the fourth leaves it at 0.
- Same-cycle issue R6 and WB R6 with cnt=1 → cnt stays 1, `hazard` on R6 remains 0 that cycle (bypass) and is 1 the next cycle.
- cnt[1]=2, assert `flush` with a simultaneous WB R1=9 → cnt[1]=0, R1=9, `hazard`=0; assert `rst` low mid-cycle → all reads return 0 immediately.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// Operand-read, write-back, issue and stall signals of the register file.
// The master side drives them from decode/write-back; the slave side is the register file.
interface reg_file_sb_if;
   // Decode operand reads
   logic [3:0]  src1_addr;
   logic        src1_valid;
   logic [3:0]  src2_addr;
   logic        src2_valid;
   logic [31:0] pc_in;
   logic [31:0] rn_value;
   logic [31:0] rm_value;
   // Write-back port
   logic [3:0]  wb_dest;
   logic [31:0] wb_value;
   logic        wb_wb_en;
   // Issue and scoreboard control
   logic        iss_valid;
   logic [3:0]  iss_dest;
   logic        iss_wb_en;
   logic        flush;
   logic        hazard;

   modport master (
      output src1_addr, src1_valid, src2_addr, src2_valid, pc_in,
      output wb_dest, wb_value, wb_wb_en,
      output iss_valid, iss_dest, iss_wb_en, flush,
      input  rn_value, rm_value, hazard
   );

   modport slave (
      input  src1_addr, src1_valid, src2_addr, src2_valid, pc_in,
      input  wb_dest, wb_value, wb_wb_en,
      input  iss_valid, iss_dest, iss_wb_en, flush,
      output rn_value, rm_value, hazard
   );
endinterface

// File: rtl/reg_file_sb.sv
// Architectural register file R0..R14 with PC on address 15, same-cycle
// write-back bypass, and a per-register pending-write counter that raises
// a decode stall when a sourced register still has writes in flight.
module reg_file_sb #(
   parameter int NREG  = 15,
   parameter int CNT_W = 2
) (
   input logic          clk,
   input logic          rst,
   reg_file_sb_if.slave bus
);

   localparam logic [3:0]       PC_ADDR = 4'd15;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [31:0]      r_regs    [NREG];
   logic [CNT_W-1:0] r_cnt     [NREG];
   logic [CNT_W-1:0] w_cnt_nxt [NREG];
   logic [NREG-1:0]  w_inc;
   logic [NREG-1:0]  w_dec;
   logic [NREG-1:0]  w_pending;
   logic             w_wr_ok;
   logic [31:0]      w_rn_value;
   logic [31:0]      w_rm_value;
   logic             w_haz1;
   logic             w_haz2;

   // Address lands in storage (not the PC alias, not beyond the array)
   function automatic logic f_is_storage(input logic [3:0] a);
      return (a != PC_ADDR) && (int'(a) < NREG);
   endfunction

   // Write-back commits only to real storage; writes aimed at the PC are dropped
   assign w_wr_ok = bus.wb_wb_en && f_is_storage(bus.wb_dest);

   // Per-register increment/decrement requests and pending status
   always_comb begin
      w_inc     = '0;
      w_dec     = '0;
      w_pending = '0;
      for (int r = 0; r < NREG; r++) begin
         w_inc[r] = bus.iss_valid && bus.iss_wb_en && (bus.iss_dest == 4'(r));
         w_dec[r] = bus.wb_wb_en && (bus.wb_dest == 4'(r));
         // The last outstanding write landing now is served by the bypass
         w_pending[r] = (r_cnt[r] != '0) && !((r_cnt[r] == CNT_ONE) && w_dec[r]);
      end
   end

   // Next counter value: flush wins, inc+dec cancel, saturate up, floor at zero
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         w_cnt_nxt[r] = r_cnt[r];
         if (bus.flush) begin
            w_cnt_nxt[r] = '0;
         end else if (w_inc[r] && !w_dec[r]) begin
            if (r_cnt[r] != CNT_MAX) w_cnt_nxt[r] = r_cnt[r] + CNT_ONE;
         end else if (w_dec[r] && !w_inc[r]) begin
            if (r_cnt[r] != '0) w_cnt_nxt[r] = r_cnt[r] - CNT_ONE;
         end
      end
   end

   // Register storage write, cleared by async reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
      end else if (w_wr_ok) begin
         r_regs[bus.wb_dest] <= bus.wb_value;
      end
   end

   // Pending-write counters, cleared by async reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) r_cnt[r] <= w_cnt_nxt[r];
      end
   end

   // Read port 1: PC alias, then write-back bypass, then storage
   always_comb begin
      w_rn_value = '0;
      if (bus.src1_addr == PC_ADDR)
         w_rn_value = bus.pc_in;
      else if (bus.wb_wb_en && (bus.wb_dest == bus.src1_addr))
         w_rn_value = bus.wb_value;
      else if (f_is_storage(bus.src1_addr))
         w_rn_value = r_regs[bus.src1_addr];
   end

   // Read port 2: PC alias, then write-back bypass, then storage
   always_comb begin
      w_rm_value = '0;
      if (bus.src2_addr == PC_ADDR)
         w_rm_value = bus.pc_in;
      else if (bus.wb_wb_en && (bus.wb_dest == bus.src2_addr))
         w_rm_value = bus.wb_value;
      else if (f_is_storage(bus.src2_addr))
         w_rm_value = r_regs[bus.src2_addr];
   end

   // Stall when a used source register still has a write outstanding
   always_comb begin
      w_haz1 = 1'b0;
      w_haz2 = 1'b0;
      if (bus.src1_valid && f_is_storage(bus.src1_addr))
         w_haz1 = w_pending[bus.src1_addr];
      if (bus.src2_valid && f_is_storage(bus.src2_addr))
         w_haz2 = w_pending[bus.src2_addr];
   end

   assign bus.rn_value = w_rn_value;
   assign bus.rm_value = w_rm_value;
   assign bus.hazard   = w_haz1 | w_haz2;

endmodule
